// File: rtl/dmem_responder.sv
// Data-memory responder: grants a tag in the same cycle a command is accepted and returns load data
// on that tag MEM_LATENCY cycles later. Up to 15 transactions may be outstanding.
module dmem_responder #(
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned WORD_INDEX_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [63:0] proc2Dmem_addr,
  input  logic [63:0] proc2Dmem_data,
  input  logic        mem_stall,
  output logic [3:0]  Dmem2proc_response,
  output logic [3:0]  Dmem2proc_tag,
  output logic [63:0] Dmem2proc_data
);

  localparam int unsigned NUM_TAGS = 15;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DATA_W   = 64;
  localparam logic [1:0]  BUS_LOAD  = 2'd1;
  localparam logic [1:0]  BUS_STORE = 2'd2;
  // The slot count holds the number of edges left before its completion cycle, so 0 means completing now.
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(MEM_LATENCY - 1);

  logic [NUM_TAGS:1]          r_busy;
  logic [NUM_TAGS:1]          r_is_load;
  logic [CNT_W-1:0]           r_count [1:NUM_TAGS];
  logic [DATA_W-1:0]          r_buf   [1:NUM_TAGS];
  logic [DATA_W-1:0]          r_mem   [0:MEM_WORDS-1];
  logic [TAG_W-1:0]           r_tag;
  logic [DATA_W-1:0]          r_data;

  logic [WORD_INDEX_BITS-1:0] w_index;
  logic                       w_is_load;
  logic                       w_is_store;
  logic                       w_accept;
  logic [TAG_W-1:0]           w_grant;
  logic [DATA_W-1:0]          w_rd_data;
  logic [TAG_W-1:0]           w_done_tag;
  logic [DATA_W-1:0]          w_done_data;
  logic                       w_unused_addr;

  assign w_index       = proc2Dmem_addr[WORD_INDEX_BITS+2:3];
  assign w_unused_addr = ^{proc2Dmem_addr[63:WORD_INDEX_BITS+3], proc2Dmem_addr[2:0]};
  assign w_rd_data     = r_mem[w_index];
  assign w_is_load     = (proc2Dmem_command == BUS_LOAD);
  assign w_is_store    = (proc2Dmem_command == BUS_STORE);

  // Lowest-numbered free tag; 0 when every tag is busy.
  always_comb begin
    w_grant = '0;
    for (int t = NUM_TAGS; t >= 1; t--) begin
      if (!r_busy[t]) w_grant = TAG_W'(t);
    end
  end

  assign w_accept = reset && (w_is_load || w_is_store) && !mem_stall && (w_grant != '0);
  assign Dmem2proc_response = w_accept ? w_grant : '0;

  // Load completing next cycle; with unit latency it is the load being accepted right now.
  always_comb begin
    w_done_tag  = '0;
    w_done_data = '0;
    if (MEM_LATENCY == 1) begin
      if (w_accept && w_is_load) begin
        w_done_tag  = w_grant;
        w_done_data = w_rd_data;
      end
    end else begin
      for (int t = 1; t <= NUM_TAGS; t++) begin
        if (r_busy[t] && r_is_load[t] && (r_count[t] == CNT_W'(1))) begin
          w_done_tag  = TAG_W'(t);
          w_done_data = r_buf[t];
        end
      end
    end
  end

  // Tag slots and completion outputs; reset drops every in-flight transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy    <= '0;
      r_is_load <= '0;
      for (int t = 1; t <= NUM_TAGS; t++) r_count[t] <= '0;
      r_tag     <= '0;
      r_data    <= '0;
    end else begin
      for (int t = 1; t <= NUM_TAGS; t++) begin
        if (r_busy[t]) begin
          if (r_count[t] == '0) r_busy[t] <= 1'b0;
          else                  r_count[t] <= r_count[t] - CNT_W'(1);
        end
      end
      if (w_accept) begin
        r_busy[w_grant]    <= 1'b1;
        r_is_load[w_grant] <= w_is_load;
        r_count[w_grant]   <= LOAD_CNT;
      end
      r_tag  <= w_done_tag;
      r_data <= w_done_data;
    end
  end

  // Backing array and load buffers keep their contents across reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      if (w_is_load) r_buf[w_grant] <= w_rd_data;
      else           r_mem[w_index] <= proc2Dmem_data;
    end
  end

  assign Dmem2proc_tag  = r_tag;
  assign Dmem2proc_data = r_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic, each cycle checked against a
// cycle-numbered model of tag occupancy, memory contents and scheduled load completions.
module tb_dmem_responder;

  localparam int unsigned LAT   = 4;
  localparam int unsigned WORDS = 1024;
  localparam logic [1:0]  C_NONE  = 2'd0;
  localparam logic [1:0]  C_LOAD  = 2'd1;
  localparam logic [1:0]  C_STORE = 2'd2;
  localparam logic [63:0] V1 = 64'hDEAD_BEEF_0000_0001;

  logic        clock;
  logic        reset;
  logic [1:0]  cmd;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        stall;
  logic [3:0]  resp;
  logic [3:0]  tag;
  logic [63:0] rdata;

  dmem_responder #(.MEM_LATENCY(LAT), .MEM_WORDS(WORDS), .WORD_INDEX_BITS(10)) dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Dmem_command  (cmd),
    .proc2Dmem_addr     (addr),
    .proc2Dmem_data     (wdata),
    .mem_stall          (stall),
    .Dmem2proc_response (resp),
    .Dmem2proc_tag      (tag),
    .Dmem2proc_data     (rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] data;
  } view_t;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    bit          known;
  } exp_t;

  int          cyc;
  int          checks;
  int          errors;
  int          busy_until [1:15];
  logic [63:0] mem_m [int];
  exp_t        exp_q [int];

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) % 64'(WORDS));
  endfunction

  function automatic logic [63:0] rand_addr(input int idx);
    logic [63:0] hi;
    hi = {$urandom, $urandom};
    return (hi << 13) | (64'(idx) << 3) | 64'($urandom_range(0, 7));
  endfunction

  task automatic model_reset();
    for (int t = 1; t <= 15; t++) busy_until[t] = -1;
    exp_q.delete();
  endtask

  // One clock cycle: drive at posedge+1, sample at the falling edge, then advance the model.
  task automatic cycle(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                       input logic s, output view_t o, output view_t e, output bit dk);
    int w;
    cmd = c; addr = a; wdata = d; stall = s;
    #4;
    o  = {resp, tag, rdata};
    e  = '0;
    dk = 1'b1;
    if ((c == C_LOAD || c == C_STORE) && !s) begin
      for (int t = 15; t >= 1; t--) if (cyc > busy_until[t]) e.resp = 4'(t);
    end
    if (exp_q.exists(cyc)) begin
      e.tag  = exp_q[cyc].tag;
      e.data = exp_q[cyc].data;
      dk     = exp_q[cyc].known;
      exp_q.delete(cyc);
    end
    w = word_of(a);
    if (e.resp != 4'd0) begin
      busy_until[e.resp] = cyc + int'(LAT);
      if (c == C_LOAD) exp_q[cyc + int'(LAT)] = '{e.resp, mem_m.exists(w) ? mem_m[w] : 64'd0, mem_m.exists(w)};
      else             mem_m[w] = d;
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  // Asserts reset for one cycle while a LOAD is offered; returns what the outputs show during reset.
  task automatic pulse_reset(output view_t o);
    reset = 1'b0; cmd = C_LOAD; addr = 64'h40; stall = 1'b0;
    #2;
    o   = {resp, tag, rdata};
    cmd = C_NONE;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    cyc++;
  endtask

  task automatic test_reset();
    view_t o, e;
    bit    dk;
    pulse_reset(o);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_outputs resp got %0d exp 0, tag got %0d exp 0, data got %h exp 0", o.resp, o.tag, o.data);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(C_NONE, 64'h0, 64'h0, 1'b0, o, e, dk);
      checks++;
      if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
        errors++;
        $display("FAIL reset_idle c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                 i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
      end
    end
  endtask

  task automatic test_store_load();
    view_t      o, e;
    bit         dk;
    logic [1:0] c;
    for (int i = 0; i < 8; i++) begin
      c = (i == 0) ? C_STORE : ((i == 1) ? C_LOAD : C_NONE);
      cycle(c, 64'h40, V1, 1'b0, o, e, dk);
      checks++;
      if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
        errors++;
        $display("FAIL store_load c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                 i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
      end
      if (i == 0 || i == 1) begin
        checks++;
        if (o.resp !== 4'(i + 1)) begin
          errors++;
          $display("FAIL store_load_grant c%0d resp got %0d exp %0d", i, o.resp, i + 1);
        end
      end
      if (i == 4) begin
        checks++;
        if (o.tag !== 4'd0) begin
          errors++;
          $display("FAIL store_silent tag got %0d exp 0", o.tag);
        end
      end
      if (i == 5) begin
        checks++;
        if (o.tag !== 4'd2 || o.data !== V1) begin
          errors++;
          $display("FAIL store_load_data tag got %0d exp 2 data got %h exp %h", o.tag, o.data, V1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    view_t o, e;
    bit    dk;
    int    er [6] = '{1, 2, 3, 4, 5, 1};
    for (int i = 0; i < 12; i++) begin
      cycle((i < 6) ? C_LOAD : C_NONE, 64'h40, 64'h0, 1'b0, o, e, dk);
      checks++;
      if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
        errors++;
        $display("FAIL back_to_back c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                 i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
      end
      if (i < 6) begin
        checks++;
        if (o.resp !== 4'(er[i])) begin
          errors++;
          $display("FAIL b2b_grant c%0d resp got %0d exp %0d", i, o.resp, er[i]);
        end
      end
      if (i >= 4 && i <= 9) begin
        checks++;
        if (o.tag !== 4'(er[i-4]) || o.data !== V1) begin
          errors++;
          $display("FAIL b2b_return c%0d tag got %0d exp %0d data got %h exp %h", i, o.tag, er[i-4], o.data, V1);
        end
      end
    end
  endtask

  task automatic test_load_store_order();
    view_t       o, e;
    bit          dk;
    logic [1:0]  c;
    logic [63:0] d;
    for (int i = 0; i < 10; i++) begin
      c = (i == 0 || i == 2) ? C_STORE : ((i == 1 || i == 3) ? C_LOAD : C_NONE);
      d = (i == 0) ? 64'h11 : 64'h22;
      cycle(c, 64'h80, d, 1'b0, o, e, dk);
      checks++;
      if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
        errors++;
        $display("FAIL order c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                 i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
      end
      if (i == 5 || i == 7) begin
        checks++;
        if (o.tag !== ((i == 5) ? 4'd2 : 4'd4) || o.data !== ((i == 5) ? 64'h11 : 64'h22)) begin
          errors++;
          $display("FAIL order_data c%0d tag got %0d data got %h exp %0d/%h", i, o.tag, o.data,
                   (i == 5) ? 2 : 4, (i == 5) ? 64'h11 : 64'h22);
        end
      end
    end
  endtask

  task automatic test_stall();
    view_t      o, e;
    bit         dk;
    logic [1:0] c;
    logic       s;
    for (int i = 0; i < 10; i++) begin
      c = (i == 2) ? C_STORE : ((i <= 3) ? C_LOAD : C_NONE);
      s = (i == 0 || i == 2);
      cycle(c, 64'h40, 64'hBAD, s, o, e, dk);
      checks++;
      if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
        errors++;
        $display("FAIL stall c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                 i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
      end
      if (i <= 1) begin
        checks++;
        if (o.resp !== 4'(i)) begin
          errors++;
          $display("FAIL stall_grant c%0d resp got %0d exp %0d", i, o.resp, i);
        end
      end
      if (i == 4 || i == 5 || i == 7) begin
        checks++;
        if (o.tag !== ((i == 4) ? 4'd0 : ((i == 5) ? 4'd1 : 4'd2)) || (i != 4 && o.data !== V1)) begin
          errors++;
          $display("FAIL stall_return c%0d tag got %0d data got %h exp data %h", i, o.tag, o.data, V1);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    view_t o, e;
    bit    dk;
    for (int i = 0; i < 20; i++) begin
      if (i == 2 || i == 16) begin
        pulse_reset(o);
        checks++;
        if (o !== '0) begin
          errors++;
          $display("FAIL reset_mid c%0d resp got %0d tag got %0d data got %h exp all 0", i, o.resp, o.tag, o.data);
        end
      end else begin
        cycle((i == 0 || i == 7 || i == 12) ? C_LOAD : C_NONE, 64'h40, 64'h0, 1'b0, o, e, dk);
        checks++;
        if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
          errors++;
          $display("FAIL reset_flow c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                   i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
        end
        if (i == 0 || i == 7 || i == 12) begin
          checks++;
          if (o.resp !== 4'd1) begin
            errors++;
            $display("FAIL reset_grant c%0d resp got %0d exp 1", i, o.resp);
          end
        end
        if (i == 4 || i == 11) begin
          checks++;
          if (o.tag !== ((i == 4) ? 4'd0 : 4'd1) || (i == 11 && o.data !== V1)) begin
            errors++;
            $display("FAIL reset_return c%0d tag got %0d data got %h exp data %h", i, o.tag, o.data, V1);
          end
        end
      end
    end
  endtask

  task automatic test_alias();
    view_t      o, e;
    bit         dk;
    logic [1:0] c;
    logic [63:0] a;
    for (int i = 0; i < 7; i++) begin
      c = (i == 0) ? C_STORE : ((i == 1) ? C_LOAD : C_NONE);
      a = (i == 0) ? 64'(WORDS) * 64'd8 : 64'h5;
      cycle(c, a, 64'h7, 1'b0, o, e, dk);
      checks++;
      if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
        errors++;
        $display("FAIL alias c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                 i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
      end
      if (i == 5) begin
        checks++;
        if (o.tag !== 4'd2 || o.data !== 64'h7) begin
          errors++;
          $display("FAIL alias_data tag got %0d exp 2 data got %h exp 7", o.tag, o.data);
        end
      end
    end
  endtask

  task automatic test_random();
    view_t       o, e;
    bit          dk;
    int          idx [8] = '{0, 1, 7, 100, 511, 512, 1022, 1023};
    logic [1:0]  c;
    logic        s;
    for (int i = 0; i < 420; i++) begin
      if (i < 8) begin
        c = C_STORE;
        s = 1'b0;
      end else if (i < 412) begin
        c = 2'($urandom_range(0, 3));
        s = ($urandom_range(0, 9) == 0);
      end else begin
        c = C_NONE;
        s = 1'b0;
      end
      cycle(c, rand_addr(idx[(i < 8) ? i : $urandom_range(0, 7)]), {$urandom, $urandom}, s, o, e, dk);
      checks++;
      if (o.resp !== e.resp || o.tag !== e.tag || (dk && o.data !== e.data)) begin
        errors++;
        $display("FAIL random c%0d resp got %0d exp %0d tag got %0d exp %0d data got %h exp %h",
                 i, o.resp, e.resp, o.tag, e.tag, o.data, e.data);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    cmd    = C_NONE;
    addr   = '0;
    wdata  = '0;
    stall  = 1'b0;
    model_reset();
    @(posedge clock); #1;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_load_store_order();
    test_stall();
    test_reset_midflight();
    test_alias();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
